// File: rtl/prn_code_gen_if.sv
// Configuration, strobe and status bundle for prn_code_gen.
// The master side configures and strobes; the slave side is the generator.
interface prn_code_gen_if #(
    parameter int unsigned SR_W    = 32,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned EP_W    = 16,
    parameter int unsigned RATIO_W = 8
) ();
    logic [SR_W-1:0]    init_state1;
    logic [SR_W-1:0]    init_state2;
    logic [SR_W-1:0]    reset_state1;
    logic [SR_W-1:0]    reset_state2;
    logic [SR_W-1:0]    fb_mask1;
    logic [SR_W-1:0]    fb_mask2;
    logic [SR_W-1:0]    out_mask1;
    logic [SR_W-1:0]    out_mask2;
    logic [CNT_W-1:0]   prn_length;
    logic [CNT_W-1:0]   prn_init;
    logic [EP_W-1:0]    epoch_length;
    logic [RATIO_W-1:0] shift_ratio;
    logic               doinit;
    logic               shift;

    logic [SR_W-1:0]    sr1;
    logic [SR_W-1:0]    sr2;
    logic [CNT_W-1:0]   chip_cnt;
    logic [EP_W-1:0]    epoch_cnt;
    logic               code_out;
    logic               prn_reset;
    logic               epoch_pulse;

    modport master (
        output init_state1, init_state2, reset_state1, reset_state2,
               fb_mask1, fb_mask2, out_mask1, out_mask2,
               prn_length, prn_init, epoch_length, shift_ratio, doinit, shift,
        input  sr1, sr2, chip_cnt, epoch_cnt, code_out, prn_reset, epoch_pulse
    );

    modport slave (
        input  init_state1, init_state2, reset_state1, reset_state2,
               fb_mask1, fb_mask2, out_mask1, out_mask2,
               prn_length, prn_init, epoch_length, shift_ratio, doinit, shift,
        output sr1, sr2, chip_cnt, epoch_cnt, code_out, prn_reset, epoch_pulse
    );
endinterface

// File: rtl/prn_code_gen.sv
// Dual-LFSR PRN code generator with sub-chip divider, chip counter and epoch counter.
// Priority each cycle is reset > doinit > shift; wrap pulses are registered one-cycle strobes.
module prn_code_gen #(
    parameter int unsigned SR_W    = 32,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned EP_W    = 16,
    parameter int unsigned RATIO_W = 8
) (
    input logic           clk,
    input logic           reset,
    prn_code_gen_if.slave bus
);

    logic [SR_W-1:0]    sr1_q, sr1_d;
    logic [SR_W-1:0]    sr2_q, sr2_d;
    logic [CNT_W-1:0]   chip_q, chip_d;
    logic [EP_W-1:0]    epoch_q, epoch_d;
    logic [RATIO_W-1:0] sub_q, sub_d;
    logic               prn_reset_q, prn_reset_d;
    logic               epoch_pulse_q, epoch_pulse_d;

    logic [CNT_W-1:0]   len_eff;
    logic [EP_W-1:0]    ep_eff;
    logic [RATIO_W-1:0] ratio_eff;
    logic               sub_end;
    logic               chip_end;
    logic               epoch_end;

    function automatic logic [SR_W-1:0] lfsr_step(input logic [SR_W-1:0] s,
                                                   input logic [SR_W-1:0] m);
        return {s[SR_W-2:0], ^(s & m)};
    endfunction

    // Zero-valued lengths/ratios behave as 1; >= keeps a shortened length from overrunning.
    always_comb begin
        len_eff   = (bus.prn_length == '0) ? CNT_W'(1) : bus.prn_length;
        ep_eff    = (bus.epoch_length == '0) ? EP_W'(1) : bus.epoch_length;
        ratio_eff = (bus.shift_ratio == '0) ? RATIO_W'(1) : bus.shift_ratio;
        sub_end   = (sub_q >= ratio_eff - RATIO_W'(1));
        chip_end  = (chip_q >= len_eff - CNT_W'(1));
        epoch_end = (epoch_q >= ep_eff - EP_W'(1));
    end

    always_comb begin
        sr1_d         = sr1_q;
        sr2_d         = sr2_q;
        chip_d        = chip_q;
        epoch_d       = epoch_q;
        sub_d         = sub_q;
        prn_reset_d   = 1'b0;
        epoch_pulse_d = 1'b0;
        if (bus.doinit) begin
            sr1_d   = bus.init_state1;
            sr2_d   = bus.init_state2;
            chip_d  = bus.prn_init;
            sub_d   = '0;
            epoch_d = '0;
        end else if (bus.shift) begin
            if (!sub_end) begin
                sub_d = sub_q + RATIO_W'(1);
            end else begin
                sub_d = '0;
                if (!chip_end) begin
                    chip_d = chip_q + CNT_W'(1);
                    sr1_d  = lfsr_step(sr1_q, bus.fb_mask1);
                    sr2_d  = lfsr_step(sr2_q, bus.fb_mask2);
                end else begin
                    chip_d      = '0;
                    sr1_d       = bus.reset_state1;
                    sr2_d       = bus.reset_state2;
                    prn_reset_d = 1'b1;
                    if (epoch_end) begin
                        epoch_d       = '0;
                        epoch_pulse_d = 1'b1;
                    end else begin
                        epoch_d = epoch_q + EP_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr1_q         <= '0;
            sr2_q         <= '0;
            chip_q        <= '0;
            epoch_q       <= '0;
            sub_q         <= '0;
            prn_reset_q   <= 1'b0;
            epoch_pulse_q <= 1'b0;
        end else begin
            sr1_q         <= sr1_d;
            sr2_q         <= sr2_d;
            chip_q        <= chip_d;
            epoch_q       <= epoch_d;
            sub_q         <= sub_d;
            prn_reset_q   <= prn_reset_d;
            epoch_pulse_q <= epoch_pulse_d;
        end
    end

    assign bus.sr1         = sr1_q;
    assign bus.sr2         = sr2_q;
    assign bus.chip_cnt    = chip_q;
    assign bus.epoch_cnt   = epoch_q;
    assign bus.prn_reset   = prn_reset_q;
    assign bus.epoch_pulse = epoch_pulse_q;
    assign bus.code_out    = (^(sr1_q & bus.out_mask1)) ^ (^(sr2_q & bus.out_mask2));

endmodule

// File: tb/tb_prn_code_gen.sv
// Directed and randomized checks of prn_code_gen against an arithmetic reference model.
module tb_prn_code_gen;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    logic [31:0] m_sr1, m_sr2, m_chip;
    logic [15:0] m_ep;
    int          m_sub;
    bit          m_prn, m_epp;

    prn_code_gen_if #(.SR_W(32), .CNT_W(32), .EP_W(16), .RATIO_W(8)) bus ();

    prn_code_gen #(.SR_W(32), .CNT_W(32), .EP_W(16), .RATIO_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic bit par(input logic [31:0] v);
        return ($countones(v) % 2) == 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: counters held as plain integers, wrap decided by arithmetic on L, R, E.
    task automatic model_update(input bit r, input bit di, input bit sh);
        longint len, ratio, ep_len;
        len    = (bus.prn_length == 0) ? 1 : longint'(bus.prn_length);
        ratio  = (bus.shift_ratio == 0) ? 1 : longint'(bus.shift_ratio);
        ep_len = (bus.epoch_length == 0) ? 1 : longint'(bus.epoch_length);
        m_prn = 0;
        m_epp = 0;
        if (r) begin
            m_sr1 = 0; m_sr2 = 0; m_chip = 0; m_ep = 0; m_sub = 0;
        end else if (di) begin
            m_sr1 = bus.init_state1; m_sr2 = bus.init_state2;
            m_chip = bus.prn_init; m_ep = 0; m_sub = 0;
        end else if (sh) begin
            if (m_sub + 1 < ratio) begin
                m_sub++;
            end else begin
                m_sub = 0;
                if (longint'(m_chip) + 1 < len) begin
                    m_chip++;
                    m_sr1 = (m_sr1 << 1) | 32'(par(m_sr1 & bus.fb_mask1));
                    m_sr2 = (m_sr2 << 1) | 32'(par(m_sr2 & bus.fb_mask2));
                end else begin
                    m_chip = 0;
                    m_sr1 = bus.reset_state1;
                    m_sr2 = bus.reset_state2;
                    m_prn = 1;
                    if (longint'(m_ep) + 1 < ep_len) m_ep++;
                    else begin
                        m_ep = 0;
                        m_epp = 1;
                    end
                end
            end
        end
    endtask

    task automatic do_cycle(input bit r, input bit di, input bit sh);
        reset = r;
        bus.doinit = di;
        bus.shift = sh;
        @(posedge clk);
        #1;
        model_update(r, di, sh);
        check("sr1", bus.sr1, m_sr1);
        check("sr2", bus.sr2, m_sr2);
        check("chip_cnt", bus.chip_cnt, m_chip);
        check("epoch_cnt", bus.epoch_cnt, m_ep);
        check("prn_reset", bus.prn_reset, m_prn);
        check("epoch_pulse", bus.epoch_pulse, m_epp);
        check("code_out", bus.code_out,
              par(m_sr1 & bus.out_mask1) ^ par(m_sr2 & bus.out_mask2));
    endtask

    task automatic cfg(input int len, input int ratio, input int ep_len, input int init);
        bus.prn_length = len;
        bus.shift_ratio = 8'(ratio);
        bus.epoch_length = 16'(ep_len);
        bus.prn_init = init;
    endtask

    initial begin
        logic [31:0] sr_exp[3];
        logic [31:0] c_exp[6];
        int npulse, nep;
        sr_exp = '{32'h3, 32'h6, 32'hD};
        n_tests = 0; n_fail = 0;
        clk = 0; reset = 1;
        bus.init_state1 = 0; bus.init_state2 = 0; bus.reset_state1 = 0; bus.reset_state2 = 0;
        bus.fb_mask1 = 0; bus.fb_mask2 = 0; bus.out_mask1 = 0; bus.out_mask2 = 0;
        bus.doinit = 0; bus.shift = 0;
        cfg(0, 0, 0, 0);

        // Reset state
        do_cycle(1, 0, 0);
        do_cycle(1, 0, 1);
        check("rst_chip", bus.chip_cnt, 0);
        check("rst_code", bus.code_out, 0);

        // LFSR sequence and code output; second set masked out
        bus.fb_mask1 = 32'h3; bus.out_mask1 = 32'h1; bus.init_state1 = 32'h1;
        bus.init_state2 = 32'hABCD; bus.fb_mask2 = 0; bus.out_mask2 = 0;
        cfg(510, 1, 0, 0);
        do_cycle(0, 1, 0);
        check("lfsr_init", bus.sr1, 32'h1);
        check("code_init", bus.code_out, 1);
        for (int i = 0; i < 3; i++) begin
            do_cycle(0, 0, 1);
            check("lfsr_seq", bus.sr1, sr_exp[i]);
            check("code_seq", bus.code_out, (i == 1) ? 0 : 1);
        end

        // Code wrap at L=4
        bus.reset_state1 = 32'h5;
        cfg(4, 1, 0, 0);
        do_cycle(0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            do_cycle(0, 0, 1);
            check("wrap_chip", bus.chip_cnt, (i + 1) % 4);
            check("wrap_pulse", bus.prn_reset, (i == 3) ? 1 : 0);
        end
        check("wrap_sr1", bus.sr1, 32'h5);
        do_cycle(0, 0, 0);
        check("wrap_pulse_one", bus.prn_reset, 0);

        // Sub-chip divider R=2, L=3
        c_exp = '{0, 1, 1, 2, 2, 0};
        cfg(3, 2, 0, 0);
        do_cycle(0, 1, 0);
        npulse = 0;
        for (int i = 0; i < 6; i++) begin
            do_cycle(0, 0, 1);
            check("ratio_chip", bus.chip_cnt, c_exp[i]);
            if (bus.prn_reset) npulse++;
        end
        check("ratio_npulse", npulse, 1);

        // Epoch counting E=3, L=2
        c_exp = '{0, 1, 1, 2, 2, 0};
        cfg(2, 1, 3, 0);
        do_cycle(0, 1, 0);
        nep = 0;
        for (int i = 0; i < 6; i++) begin
            do_cycle(0, 0, 1);
            check("epoch_cnt_seq", bus.epoch_cnt, c_exp[i]);
            if (bus.epoch_pulse) nep++;
        end
        check("epoch_with_prn", bus.prn_reset & bus.epoch_pulse, 1);
        check("epoch_npulse", nep, 1);

        // doinit+shift collision, then reset mid-period
        cfg(4, 1, 0, 2);
        do_cycle(0, 1, 1);
        check("coll_chip", bus.chip_cnt, 2);
        check("coll_sr1", bus.sr1, 32'h1);
        do_cycle(0, 0, 1);
        do_cycle(1, 0, 1);
        check("midrst_sr1", bus.sr1, 0);
        check("midrst_pulse", bus.prn_reset, 0);
        do_cycle(0, 0, 0);
        check("post_rst_pulse", bus.prn_reset | bus.epoch_pulse, 0);

        // Init index beyond length wraps on first advance
        cfg(4, 1, 0, 7);
        do_cycle(0, 1, 0);
        do_cycle(0, 0, 1);
        check("bigi_chip", bus.chip_cnt, 0);
        check("bigi_pulse", bus.prn_reset, 1);

        // Randomized blocks with mid-period length changes
        for (int b = 0; b < 4; b++) begin
            bus.init_state1 = $urandom; bus.init_state2 = $urandom;
            bus.reset_state1 = $urandom; bus.reset_state2 = $urandom;
            bus.fb_mask1 = $urandom; bus.fb_mask2 = $urandom;
            bus.out_mask1 = (b == 3) ? 0 : $urandom; bus.out_mask2 = $urandom;
            cfg($urandom_range(0, 8), $urandom_range(0, 3), $urandom_range(0, 4),
                $urandom_range(0, 10));
            do_cycle(0, 1, 0);
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 99) == 0) bus.prn_length = $urandom_range(0, 8);
                do_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
                         $urandom_range(0, 2) != 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prn_code_gen.md
PRN_CODE_GEN -- requirements
Module: prn_code_gen

Interface
REQ-001 Parameter SR_W, default 32: width of each LFSR state and mask.
REQ-002 Parameter CNT_W, default 32: width of chip counter, length and init values.
REQ-003 Parameter EP_W, default 16: width of epoch counter and epoch length.
REQ-004 Parameter RATIO_W, default 8: width of sub-chip counter and shift_ratio.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 init_state1, init_state2  in  SR_W each  LFSR values loaded on doinit.
REQ-008 reset_state1, reset_state2  in  SR_W each  LFSR values loaded on code wrap.
REQ-009 fb_mask1, fb_mask2  in  SR_W each  feedback tap masks.
REQ-010 out_mask1, out_mask2  in  SR_W each  output tap masks.
REQ-011 prn_length  in  CNT_W  chips per code period.
REQ-012 prn_init  in  CNT_W  chip index loaded on doinit.
REQ-013 epoch_length  in  EP_W  code periods per epoch.
REQ-014 shift_ratio  in  RATIO_W  shift strobes per chip.
REQ-015 doinit  in  1  load strobe.
REQ-016 shift  in  1  advance strobe.
REQ-017 sr1, sr2  out  SR_W each  current LFSR states.
REQ-018 chip_cnt  out  CNT_W  current chip index.
REQ-019 epoch_cnt  out  EP_W  current code-period index.
REQ-020 code_out  out  1  current code chip.
REQ-021 prn_reset  out  1  code-wrap pulse.
REQ-022 epoch_pulse  out  1  epoch-wrap pulse.

Function
REQ-023 Priority per cycle SHALL be reset > doinit > shift; a shift coinciding with doinit SHALL be ignored.
REQ-024 doinit SHALL load sr1<=init_state1, sr2<=init_state2, chip_cnt<=prn_init, sub_cnt<=0 and epoch_cnt<=0; pulse outputs SHALL be 0 on the following cycle.
REQ-025 Internal sub_cnt SHALL count shift strobes 0..R-1, where R=max(shift_ratio,1); a chip advance SHALL occur on a shift with sub_cnt==R-1, and sub_cnt SHALL then return to 0.
REQ-026 The LFSR step SHALL be sr <= {sr[SR_W-2:0], ^(sr & fb_mask)}, applied independently to sr1 and sr2.
REQ-027 code_out SHALL be combinational: ^(sr1 & out_mask1) XOR ^(sr2 & out_mask2); a zero out_mask SHALL contribute 0.
REQ-028 Let L=max(prn_length,1). On a chip advance with chip_cnt<L-1: chip_cnt+1 and both LFSRs step.
REQ-029 On a chip advance with chip_cnt>=L-1 (wrap): chip_cnt<=0, sr1<=reset_state1, sr2<=reset_state2, and prn_reset=1 for exactly the next cycle.
REQ-030 With E=max(epoch_length,1), each wrap SHALL increment epoch_cnt modulo E; on wrap with epoch_cnt==E-1: epoch_cnt<=0 and epoch_pulse=1 for the next cycle, coincident with prn_reset.
REQ-031 prn_init>=L SHALL be accepted; the first chip advance SHALL then wrap.
REQ-032 Configuration inputs other than the strobes SHALL be sampled combinationally each cycle; a mid-period prn_length change SHALL take effect on the next advance compare.
REQ-033 Without shift or doinit, all state SHALL hold.

Reset
REQ-034 Reset SHALL force sr1, sr2, chip_cnt, sub_cnt and epoch_cnt to 0, and prn_reset and epoch_pulse to 0; code_out is therefore 0.
REQ-035 Reset asserted mid-period SHALL abort the period; following reset release, no pulse SHALL fire until a real wrap.

Verification
REQ-036 fb_mask1=0x3, out_mask1=0x1, init_state1=0x1, set2 masks=0, R=1, L=510; doinit, then 3 shifts -> sr1 0x1,0x3,0x6,0xD; code_out 1,1,0,1.
REQ-037 L=4, prn_init=0, reset_state1=0x5, R=1; 4 shifts -> chip_cnt 1,2,3,0; prn_reset high exactly 1 cycle after 4th shift; sr1=0x5.
REQ-038 shift_ratio=2, L=3; 6 shifts -> chip_cnt changes only on shifts 2,4,6; one prn_reset after shift 6.
REQ-039 epoch_length=3, L=2, R=1; 6 shifts -> epoch_cnt 1,2,0; epoch_pulse once, with 3rd prn_reset.
REQ-040 doinit and shift in the same cycle -> load values only; reset during counting -> all outputs 0, no pulses.
REQ-041 prn_init=7 with L=4 -> first shift wraps: chip_cnt=0, prn_reset pulses.
